// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button / slide-switch conditioning path.
// Used by btn_debounce and btn_debounce_ch.
package btn_pkg;

   // Counter width for a counter that must reach n-1. Never returns less than 1 bit.
   function automatic int clog2_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // Pin level seen when the button is not pressed.
   function automatic logic release_level(input logic active_high);
      return active_high ? 1'b0 : 1'b1;
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single input channel: 2-FF synchronizer, debounce counter, press/release pulses
// and one-shot long-press detection.
module btn_debounce_ch
   import btn_pkg::*;
#(
   parameter int DB_CYCLES   = 2_000_000,
   parameter int LONG_CYCLES = 100_000_000,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   localparam int              DB_W      = clog2_w(DB_CYCLES);
   localparam int              HOLD_W    = clog2_w(LONG_CYCLES);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic            RELEASED  = release_level(ACTIVE_HIGH != 0);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_level;
   logic              r_press;
   logic              r_release;
   logic              r_long;
   logic              r_long_fired;
   logic [DB_W-1:0]   r_db_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              w_p;

   // Synchronizer resets to the idle pin level so reset never looks like a press.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= RELEASED;
         r_sync2 <= RELEASED;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   assign w_p = (ACTIVE_HIGH != 0) ? r_sync2 : ~r_sync2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_level   <= 1'b0;
         r_db_cnt  <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         if (w_p == r_level) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_level   <= w_p;
            r_db_cnt  <= '0;
            r_press   <= w_p;
            r_release <= ~w_p;
         end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
         end
      end
   end

   // Once fired, the long press stays latched until the release is accepted.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hold_cnt   <= '0;
         r_long_fired <= 1'b0;
         r_long       <= 1'b0;
      end else begin
         r_long <= 1'b0;
         if (!r_level) begin
            r_hold_cnt   <= '0;
            r_long_fired <= 1'b0;
         end else if (!r_long_fired && (r_hold_cnt == HOLD_LAST)) begin
            r_long       <= 1'b1;
            r_long_fired <= 1'b1;
         end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;

endmodule

// File: rtl/btn_debounce.sv
// Conditions raw board buttons/switches into clean synchronous levels and events,
// one independent btn_debounce_ch per channel.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DB_CYCLES   = 2_000_000,
   parameter int LONG_CYCLES = 100_000_000,
   parameter int ACTIVE_HIGH = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] press_pulse,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_pulse
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      btn_debounce_ch #(
         .DB_CYCLES   (DB_CYCLES),
         .LONG_CYCLES (LONG_CYCLES),
         .ACTIVE_HIGH (ACTIVE_HIGH)
      ) u_ch (
         .i_clk     (clk),
         .i_rst_n   (rst_n),
         .i_btn     (btn_in[g]),
         .o_level   (btn_level[g]),
         .o_press   (press_pulse[g]),
         .o_release (release_pulse[g]),
         .o_long    (long_pulse[g])
      );
   end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: an active-high instance for the main scenarios
// and an active-low instance for pin polarity.
module tb_btn_debounce;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] btn_a, lvl_a, prs_a, rel_a, lng_a;
   logic [N-1:0] btn_b, lvl_b, prs_b, rel_b, lng_b;

   int n_checks = 0;
   int n_fail   = 0;
   int long2_cnt = 0;
   int press1_cnt = 0;

   always #5 clk = ~clk;

   btn_debounce #(.N_CH(N), .DB_CYCLES(8), .LONG_CYCLES(32), .ACTIVE_HIGH(1)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_a), .btn_level(lvl_a),
      .press_pulse(prs_a), .release_pulse(rel_a), .long_pulse(lng_a));

   btn_debounce #(.N_CH(N), .DB_CYCLES(8), .LONG_CYCLES(32), .ACTIVE_HIGH(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_b), .btn_level(lvl_b),
      .press_pulse(prs_b), .release_pulse(rel_b), .long_pulse(lng_b));

   always @(negedge clk) begin
      if (lng_a[2]) long2_cnt++;
      if (prs_a[1]) press1_cnt++;
   end

   typedef struct {
      logic [N-1:0] in;
      int           cyc;
      logic [N-1:0] level;
      logic [N-1:0] press;
      logic [N-1:0] rel;
      logic [N-1:0] lng;
   } vec_t;

   vec_t vecs[8];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      logic [N-1:0] acc;
      int           p0;
      int           l0;

      rst_n = 1'b0;
      btn_a = '0;
      btn_b = '1;

      // 1: reset and idle
      tick(3);
      check("rst_level_a", lvl_a, 4'b0000);
      check("rst_pulses_a", prs_a | rel_a | lng_a, 4'b0000);
      check("rst_level_b", lvl_b, 4'b0000);
      rst_n = 1'b1;
      acc = '0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         acc = acc | lvl_a | prs_a | rel_a | lng_a | lvl_b | prs_b | rel_b | lng_b;
      end
      check("idle_activity", acc, 4'b0000);

      // 2: 7-cycle glitch rejected, then clean press/release on channel 0
      vecs[0] = '{4'b0001,  7, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[1] = '{4'b0000, 12, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[2] = '{4'b0001,  9, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      vecs[3] = '{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
      vecs[4] = '{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      vecs[5] = '{4'b0000,  9, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
      vecs[6] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      vecs[7] = '{4'b0000,  1, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      for (int i = 0; i < 8; i++) begin
         btn_a = vecs[i].in;
         tick(vecs[i].cyc);
         check($sformatf("vec%0d_level", i), lvl_a, vecs[i].level);
         check($sformatf("vec%0d_press", i), prs_a, vecs[i].press);
         check($sformatf("vec%0d_rel", i), rel_a, vecs[i].rel);
         check($sformatf("vec%0d_long", i), lng_a, vecs[i].lng);
      end

      // 3: bounce on channel 1, then a settled press
      p0 = press1_cnt;
      foreach (vecs[i]) ; // keep table untouched
      for (int k = 0; k < 3; k++) begin
         btn_a[1] = 1'b1;
         tick(3 + 2 * k);
         btn_a[1] = 1'b0;
         tick(2);
      end
      check("bounce_level1", {3'b000, lvl_a[1]}, 4'b0000);
      check("bounce_press_cnt", 4'(press1_cnt - p0), 4'd0);
      btn_a[1] = 1'b1;
      tick(9);
      check("bounce_press1_early", {3'b000, prs_a[1]}, 4'b0000);
      tick(1);
      check("bounce_press1", {3'b000, prs_a[1]}, 4'b0001);

      // 4: long press on channel 2, no auto-repeat, release, re-arm
      btn_a[2] = 1'b1;
      tick(10);
      check("long_press2", {3'b000, prs_a[2]}, 4'b0001);
      tick(31);
      check("long2_early", {3'b000, lng_a[2]}, 4'b0000);
      tick(1);
      check("long2_fire", {3'b000, lng_a[2]}, 4'b0001);
      tick(1);
      check("long2_one_cycle", {3'b000, lng_a[2]}, 4'b0000);
      l0 = long2_cnt;
      tick(200);
      check("long2_no_repeat", 4'(long2_cnt - l0), 4'd0);
      btn_a[2] = 1'b0;
      tick(9);
      check("rel2_early", {3'b000, rel_a[2]}, 4'b0000);
      tick(1);
      check("rel2", {3'b000, rel_a[2]}, 4'b0001);
      btn_a[2] = 1'b1;
      tick(41);
      check("long2_rearm_early", {3'b000, lng_a[2]}, 4'b0000);
      tick(1);
      check("long2_rearm", {3'b000, lng_a[2]}, 4'b0001);
      check("long2_total", 4'(long2_cnt), 4'd1);

      // 5: reset in the middle of a hold on channel 3
      btn_a = 4'b1000;
      tick(20);
      check("hold3_level", {3'b000, lvl_a[3]}, 4'b0001);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_clr_level", lvl_a, 4'b0000);
      check("async_clr_pulses", prs_a | rel_a | lng_a, 4'b0000);
      tick(2);
      rst_n = 1'b1;
      tick(9);
      check("rst3_press_early", {3'b000, prs_a[3]}, 4'b0000);
      tick(1);
      check("rst3_press", {3'b000, prs_a[3]}, 4'b0001);
      tick(31);
      check("rst3_long_early", {3'b000, lng_a[3]}, 4'b0000);
      tick(1);
      check("rst3_long", {3'b000, lng_a[3]}, 4'b0001);

      // 6: active-low pins
      check("pol_idle_level", lvl_b, 4'b0000);
      btn_b[0] = 1'b0;
      tick(9);
      check("pol_press_early", prs_b, 4'b0000);
      tick(1);
      check("pol_press", prs_b, 4'b0001);
      check("pol_level", lvl_b, 4'b0001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Input-side counterpart of the LED output path: conditions the board push-buttons and slide switches into clean, clock-synchronous levels and events.
- Per channel: 2-FF synchronizer, debounce counter, press/release pulse generation, and long-press detection.
- Sits between package pins and user logic, e.g. the LED counter, mode selects and the test FSMs.
- One clock domain.

Parameters:
- N_CH, 4, number of button/switch channels.
- DB_CYCLES, 2_000_000, cycles the input must stay at a new level before it is accepted (20 ms at 100 MHz); legal range >= 2.
- LONG_CYCLES, 100_000_000, cycles of continuous debounced press before long_pulse fires (1 s at 100 MHz); legal range >= 2.
- ACTIVE_HIGH, 1, 1 = pin reads 1 when pressed (board buttons); 0 = pin reads 0 when pressed.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  N_CH  raw asynchronous pin levels.
- btn_level  output  N_CH  debounced level, 1 = pressed (polarity normalised).
- press_pulse  output  N_CH  one-cycle pulse on accepted press.
- release_pulse  output  N_CH  one-cycle pulse on accepted release.
- long_pulse  output  N_CH  one-cycle pulse when a press has been held LONG_CYCLES.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. All flops reset on the falling edge of rst_n, independent of clk.
- Reset values:
  - btn_level, press_pulse, release_pulse and long_pulse are all 0.
  - Synchronizer flops reset to the released pin level (ACTIVE_HIGH ? 0 : 1).
  - All counters reset to 0.
- Normalisation: p = ACTIVE_HIGH ? sync2 : ~sync2, where sync2 is the second synchronizer stage. Channels are fully independent.
- Debounce counter db_cnt, width clog2(DB_CYCLES), evaluated each cycle:
  - p == btn_level: db_cnt <= 0.
  - p != btn_level and db_cnt == DB_CYCLES-1: btn_level <= p, db_cnt <= 0, and press_pulse (p=1) or release_pulse (p=0) asserts on the next cycle edge, concurrent with the btn_level change.
  - otherwise: db_cnt <= db_cnt+1.
- Latency: a clean pin step reaches btn_level and the pulse exactly 2 + DB_CYCLES clk edges after the pin change is first sampled.
- Glitch rejection: any return of p to btn_level before the count completes clears db_cnt. A bounce shorter than DB_CYCLES produces no output change.
- Long press, counter hold_cnt, width clog2(LONG_CYCLES):
  - btn_level == 0: hold_cnt <= 0, long_fired <= 0.
  - btn_level == 1, long_fired == 0, hold_cnt == LONG_CYCLES-1: long_pulse asserts for 1 cycle, long_fired <= 1, hold_cnt holds.
  - btn_level == 1, otherwise: hold_cnt increments.
  - After firing, no further long_pulse until a release is accepted. No auto-repeat.
- Pulses are registered, high for exactly one cycle, and never asserted while rst_n = 0.
- press_pulse and release_pulse are mutually exclusive per channel. long_pulse never coincides with press_pulse, given LONG_CYCLES >= 2.
- Reset mid-operation: all state is cleared immediately.
  - Button still held at deassert: registers as a fresh press after 2 + DB_CYCLES cycles, with press_pulse.
  - A long press in progress restarts its count.

Decomposition:
- Shared package btn_pkg: the release-level constant and the clog2 width helper for the counter widths.
- One sub-module, btn_debounce_ch: synchronizer, db_cnt, hold_cnt and pulse flops for a single channel. The top module instantiates it N_CH times via generate and does no other logic.

Test Plan:
All scenarios use the sim overrides DB_CYCLES = 8, LONG_CYCLES = 32, ACTIVE_HIGH = 1.
1. Reset/idle: rst_n low for 3 cycles, btn_in = 0 -> all outputs 0 and stay 0 for 100 cycles after release.
2. Clean press: btn_in[0] rises -> press_pulse[0] high exactly 10 cycles later for 1 cycle. btn_level[0] = 1 from the same cycle. Other channels stay 0.
3. Bounce: btn_in[1] toggles with high periods of 3, 5 and 7 cycles separated by 2-cycle lows -> no output activity. Then held high -> press_pulse[1] 10 cycles after the final rise.
4. Long press: hold btn_in[2] -> press_pulse at +10, long_pulse at +42, and no second long_pulse over the next 200 cycles. Release -> release_pulse at +10 after the release edge. Press again -> long_pulse fires again.
5. Reset mid-count: btn_in[3] held, rst_n pulsed low at cycle 20 of the hold -> outputs clear asynchronously. After deassert, press_pulse[3] fires 10 cycles later and long_pulse fires 42 cycles after deassert.
6. Polarity: ACTIVE_HIGH = 0, btn_in idle at 1 -> btn_level = 0. Driving a 0 produces press_pulse after 10 cycles.
